// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: register ids, status codes and the halt FSM state type.
package y86_pkg;

    typedef logic [3:0] reg_id_t;
    typedef logic [2:0] stat_t;

    localparam reg_id_t RNONE = 4'hF;
    localparam reg_id_t RRSP  = 4'h4;

    localparam stat_t STAT_AOK = 3'd1;
    localparam stat_t STAT_HLT = 3'd2;
    localparam stat_t STAT_ADR = 3'd3;
    localparam stat_t STAT_INS = 3'd4;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } halt_state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: selects a register by id, RNONE (or any id past NREG) reads 0.
module regfile_read_port
    import y86_pkg::*;
#(
    parameter int NREG = 15,
    parameter int W    = 64
) (
    input  logic [NREG-1:0][W-1:0] regs,
    input  reg_id_t                sel,
    output logic [W-1:0]           val
);

    // Mux the selected register onto the port; ids without storage read as zero.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
        val = '0;
        if (sel < reg_id_t'(NREG)) begin
            val = regs[sel];
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file and commit point of the SEQ core: two write ports
// (M over E on a shared id), three combinational read ports and a sticky halt latch.
module register_file
    import y86_pkg::*;
#(
    parameter int NREG = 15,
    parameter int W    = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    srcA,
    input  logic [3:0]    srcB,
    output logic [W-1:0]  valA,
    output logic [W-1:0]  valB,
    input  logic [3:0]    dstE,
    input  logic [W-1:0]  valE,
    input  logic [3:0]    dstM,
    input  logic [W-1:0]  valM,
    input  logic [2:0]    stat,
    output logic          halted,
    input  logic [3:0]    dbg_sel,
    output logic [W-1:0]  dbg_val
);

    logic [NREG-1:0][W-1:0] regs_q, regs_d;
    halt_state_t            state_q, state_d;
    logic                   commit;

    // Next-state: halt FSM plus write decode; the M write is applied last so it wins a shared id.
    always_comb begin
        regs_d  = regs_q;
        state_d = state_q;
        commit  = (stat == STAT_AOK) && (state_q == ST_RUN);

        if ((state_q == ST_RUN) && (stat != STAT_AOK)) begin
            state_d = ST_HALTED;
        end

        if (commit) begin
            if (reg_id_t'(dstE) != RNONE) begin
                regs_d[dstE] = valE;
            end
            if (reg_id_t'(dstM) != RNONE) begin
                regs_d[dstM] = valM;
            end
        end
    end

    // State register; the whole array is cleared on reset so reads show 0 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register array is reset on purpose: architectural state must read 0 out of reset.
            regs_q  <= '0;
            state_q <= ST_RUN;
        end else begin
            // NOTE: non-blocking assignments for all flops so every update sees pre-edge values.
            regs_q  <= regs_d;
            state_q <= state_d;
        end
    end

    assign halted = (state_q == ST_HALTED);

    regfile_read_port #(.NREG(NREG), .W(W)) u_port_a (
        .regs (regs_q),
        .sel  (srcA),
        .val  (valA)
    );

    regfile_read_port #(.NREG(NREG), .W(W)) u_port_b (
        .regs (regs_q),
        .sel  (srcB),
        .val  (valB)
    );

    regfile_read_port #(.NREG(NREG), .W(W)) u_port_dbg (
        .regs (regs_q),
        .sel  (dbg_sel),
        .val  (dbg_val)
    );

endmodule
